// File: rtl/tdc_uart_framer_pkg.sv
// -----------------------------------------------------------------------------
// tdc_uart_framer_pkg
// Shared definitions for the TDC-to-UART framer:
//   state_t        frame FSM state encoding
//   SYNC_DEFAULT   default frame start byte
//   DIG_OUT        width of the digital byte output towards the UART
//   clog2_min1()   index width helper that never returns 0
// -----------------------------------------------------------------------------
package tdc_uart_framer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_LATCH,
      ST_SYNC,
      ST_HDR,
      ST_DATA,
      ST_CSUM
   } state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam int         DIG_OUT      = 8;

   // A one-entry selector still needs a 1-bit index.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tdc_uart_framer_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. The search starts at the
// channel after the last one served and wraps around.
//   req    in   N_CH    request vector (1 = channel has data)
//   last   in   PTR_W   index of the channel served last
//   grant  out  PTR_W   selected channel index (0 when nothing requested)
//   valid  out  1       at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
   import tdc_uart_framer_pkg::*;
#(
   parameter  int N_CH  = 4,
   localparam int PTR_W = clog2_min1(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [PTR_W-1:0] last,
   output logic [PTR_W-1:0] grant,
   output logic             valid
);

   int idx;

   // Walk the offsets from far to near so the nearest requester after
   // 'last' is the final (winning) assignment.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         idx = int'(last) + 1 + i;
         if (idx >= N_CH) begin
            idx = idx - N_CH;
         end
         if (req[idx]) begin
            grant = PTR_W'(idx);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tdc_uart_framer.sv
// -----------------------------------------------------------------------------
// tdc_uart_framer
// Pulls one TDC word at a time from N_CH FIFOs (round-robin) and sends it to a
// UART transmitter as a frame: SYNC, HDR {seq, channel}, NB_WORD/8 data bytes
// (LSB first), CSUM (XOR of HDR and data bytes).
//   iClk       in   1             clock, rising edge
//   iRst       in   1             asynchronous active-high reset
//   iEnable    in   1             allows a new frame to start
//   iEmpty     in   N_CH          per-channel FIFO empty flags
//   oReadEN    out  N_CH          one-hot single-cycle FIFO read pulse
//   iData      in   N_CH*NB_WORD  channel k at [k*NB_WORD +: NB_WORD]
//   oTxByte    out  8             byte to the UART
//   oTxValid   out  1             oTxByte valid
//   iTxReady   in   1             UART accepts the byte
//   oBusy      out  1             frame in progress (state not IDLE)
//   oSeq       out  4             sequence number of the next frame
// -----------------------------------------------------------------------------
module tdc_uart_framer
   import tdc_uart_framer_pkg::*;
#(
   parameter int         NB_WORD = 32,
   parameter int         N_CH    = 4,
   parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
   input  logic                      iClk,
   input  logic                      iRst,
   input  logic                      iEnable,
   input  logic [N_CH-1:0]           iEmpty,
   output logic [N_CH-1:0]           oReadEN,
   input  logic [N_CH*NB_WORD-1:0]   iData,
   output logic [DIG_OUT-1:0]        oTxByte,
   output logic                      oTxValid,
   input  logic                      iTxReady,
   output logic                      oBusy,
   output logic [3:0]                oSeq
);

   localparam int PTR_W  = clog2_min1(N_CH);
   localparam int NBYTES = NB_WORD / 8;
   localparam int CNT_W  = clog2_min1(NBYTES);

   state_t             state_reg;
   logic [PTR_W-1:0]   sel_reg;
   logic [PTR_W-1:0]   last_reg;
   logic [NB_WORD-1:0] word_reg;
   logic [CNT_W-1:0]   byte_cnt_reg;
   logic [7:0]         csum_reg;
   logic [3:0]         seq_reg;

   logic [PTR_W-1:0]   grant;
   logic               grant_valid;
   logic [7:0]         hdr_byte;
   logic               tx_fire;

   logic [NB_WORD-1:0] ch_word [N_CH];

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch_word
         assign ch_word[gi] = iData[gi*NB_WORD +: NB_WORD];
      end
   endgenerate

   rr_arbiter #(
      .N_CH (N_CH)
   ) u_rr_arbiter (
      .req   (~iEmpty),
      .last  (last_reg),
      .grant (grant),
      .valid (grant_valid)
   );

   assign hdr_byte = {seq_reg, 4'(sel_reg)};
   assign tx_fire  = oTxValid & iTxReady;
   assign oSeq     = seq_reg;

   // The next byte is always loaded on the transfer of the current one, so
   // oTxByte is held untouched for as long as the UART stalls.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_reg    <= ST_IDLE;
         sel_reg      <= '0;
         last_reg     <= PTR_W'(N_CH - 1);
         word_reg     <= '0;
         byte_cnt_reg <= '0;
         csum_reg     <= '0;
         seq_reg      <= '0;
         oReadEN      <= '0;
         oTxByte      <= '0;
         oTxValid     <= 1'b0;
         oBusy        <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (iEnable && grant_valid) begin
                  sel_reg        <= grant;
                  oReadEN        <= '0;
                  oReadEN[grant] <= 1'b1;
                  oBusy          <= 1'b1;
                  state_reg      <= ST_READ;
               end
            end

            ST_READ: begin
               oReadEN   <= '0;
               state_reg <= ST_LATCH;
            end

            // FIFO data appears one cycle after the read pulse.
            ST_LATCH: begin
               word_reg  <= ch_word[sel_reg];
               oTxByte   <= SYNC;
               oTxValid  <= 1'b1;
               state_reg <= ST_SYNC;
            end

            ST_SYNC: begin
               if (tx_fire) begin
                  oTxByte   <= hdr_byte;
                  csum_reg  <= hdr_byte;
                  state_reg <= ST_HDR;
               end
            end

            ST_HDR: begin
               if (tx_fire) begin
                  oTxByte      <= word_reg[7:0];
                  word_reg     <= word_reg >> 8;
                  byte_cnt_reg <= '0;
                  state_reg    <= ST_DATA;
               end
            end

            // csum_reg accumulates the byte being transferred right now.
            ST_DATA: begin
               if (tx_fire) begin
                  csum_reg <= csum_reg ^ oTxByte;
                  if (byte_cnt_reg == CNT_W'(NBYTES - 1)) begin
                     oTxByte   <= csum_reg ^ oTxByte;
                     state_reg <= ST_CSUM;
                  end else begin
                     oTxByte      <= word_reg[7:0];
                     word_reg     <= word_reg >> 8;
                     byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                  end
               end
            end

            ST_CSUM: begin
               if (tx_fire) begin
                  seq_reg      <= seq_reg + 4'd1;
                  last_reg     <= sel_reg;
                  oTxValid     <= 1'b0;
                  oTxByte      <= '0;
                  oBusy        <= 1'b0;
                  csum_reg     <= '0;
                  byte_cnt_reg <= '0;
                  state_reg    <= ST_IDLE;
               end
            end

            default: begin
               oReadEN   <= '0;
               oTxValid  <= 1'b0;
               oBusy     <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_uart_framer.sv
// -----------------------------------------------------------------------------
// tb_tdc_uart_framer
// Directed bench for tdc_uart_framer (N_CH=4, NB_WORD=32). Small FIFO models
// with one-cycle read latency feed the DUT; a byte monitor collects every
// UART transfer and the results are compared with hand-computed frames.
// -----------------------------------------------------------------------------
module tb_tdc_uart_framer;

   localparam int NB_WORD = 32;
   localparam int N_CH    = 4;

   logic          iClk = 1'b0;
   logic          iRst;
   logic          iEnable;
   logic [3:0]    iEmpty;
   logic [3:0]    oReadEN;
   logic [127:0]  iData;
   logic [7:0]    oTxByte;
   logic          oTxValid;
   logic          iTxReady;
   logic          oBusy;
   logic [3:0]    oSeq;

   int checks   = 0;
   int failures = 0;

   always #5 iClk = ~iClk;

   tdc_uart_framer #(
      .NB_WORD (NB_WORD),
      .N_CH    (N_CH),
      .SYNC    (8'hA5)
   ) dut (
      .iClk     (iClk),
      .iRst     (iRst),
      .iEnable  (iEnable),
      .iEmpty   (iEmpty),
      .oReadEN  (oReadEN),
      .iData    (iData),
      .oTxByte  (oTxByte),
      .oTxValid (oTxValid),
      .iTxReady (iTxReady),
      .oBusy    (oBusy),
      .oSeq     (oSeq)
   );

   // ---------------- FIFO models (one-cycle read latency) ----------------
   logic [31:0] mem [4][32];
   int          wr_ptr [4]    = '{default: 0};
   int          rd_ptr [4]    = '{default: 0};
   logic [31:0] fifo_dout [4] = '{default: 32'h0};

   always @(posedge iClk) begin
      for (int k = 0; k < 4; k++) begin
         if (oReadEN[k]) begin
            fifo_dout[k] <= mem[k][rd_ptr[k] % 32];
            rd_ptr[k]    <= rd_ptr[k] + 1;
         end
      end
   end

   always_comb begin
      iEmpty = '1;
      iData  = '0;
      for (int k = 0; k < 4; k++) begin
         iEmpty[k]        = (wr_ptr[k] == rd_ptr[k]);
         iData[k*32 +: 32] = fifo_dout[k];
      end
   end

   task automatic push(input int ch, input logic [31:0] w);
      mem[ch][wr_ptr[ch] % 32] = w;
      wr_ptr[ch] = wr_ptr[ch] + 1;
   endtask

   task automatic flush();
      for (int k = 0; k < 4; k++) wr_ptr[k] = rd_ptr[k];
   endtask

   // ---------------- UART ready driver ----------------
   logic       stall_mode = 1'b0;
   logic [3:0] stall_pat  = 4'b1001;   // 1,0,0,1 repeating

   initial begin
      int k;
      k = 0;
      iTxReady = 1'b1;
      forever begin
         @(posedge iClk);
         #1;
         if (stall_mode) begin
            iTxReady = stall_pat[k];
            k = (k + 1) % 4;
         end else begin
            iTxReady = 1'b1;
         end
      end
   end

   // ---------------- Monitor (samples on the falling edge) ----------------
   logic [7:0] rx_q [$];
   int         rd_cnt       = 0;
   int         onehot_err   = 0;
   int         stall_viol   = 0;
   int         stall_cycles = 0;
   logic       stalled_prev = 1'b0;
   logic [7:0] prev_byte    = 8'h00;

   always @(negedge iClk) begin
      if (oTxValid && iTxReady) rx_q.push_back(oTxByte);
      if (stalled_prev && oTxValid && (oTxByte != prev_byte)) stall_viol++;
      if (oTxValid && !iTxReady) stall_cycles++;
      stalled_prev = oTxValid && !iTxReady;
      prev_byte    = oTxByte;
      if (oReadEN != 4'b0000) begin
         rd_cnt++;
         if ($countones(oReadEN) != 1) onehot_err++;
      end
   end

   // ---------------- Checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_readen"}, 32'(oReadEN),  32'h0);
      chk({tag, "_valid"},  32'(oTxValid), 32'h0);
      chk({tag, "_byte"},   32'(oTxByte),  32'h0);
      chk({tag, "_busy"},   32'(oBusy),    32'h0);
      chk({tag, "_seq"},    32'(oSeq),     32'h0);
   endtask

   task automatic chk_bytes(input string tag, input logic [7:0] exp_q [$]);
      chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
      end
   endtask

   // Wait for the framer to finish all frames it will take.
   task automatic wait_done(input string tag, input int bound);
      int c;
      c = 0;
      do begin
         @(negedge iClk);
         c++;
      end while (!(oBusy == 1'b0 && (iEmpty == 4'hF || !iEnable)) && c < bound);
      chk({tag, "_done"}, 32'(c < bound), 32'h1);
   endtask

   task automatic wait_bytes(input string tag, input int n, input int bound);
      int c;
      c = 0;
      while (rx_q.size() < n && c < bound) begin
         @(negedge iClk);
         c++;
      end
      chk({tag, "_reached"}, 32'(rx_q.size() >= n), 32'h1);
   endtask

   task automatic do_reset();
      @(negedge iClk);
      iRst    = 1'b1;
      iEnable = 1'b0;
      repeat (2) @(negedge iClk);
      iRst = 1'b0;
      flush();
      rx_q.delete();
      rd_cnt     = 0;
      stall_viol = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- Stimulus ----------------
   initial begin
      logic [7:0] exp_q [$];

      iRst    = 1'b1;
      iEnable = 1'b0;
      repeat (3) @(negedge iClk);
      chk_reset_outputs("por");
      iRst = 1'b0;
      @(negedge iClk);

      // Single frame, channel 0. Checksum 00^44^33^22^11 = 44.
      push(0, 32'h11223344);
      rx_q.delete();
      rd_cnt = 0;
      iEnable = 1'b1;
      wait_done("s1", 200);
      exp_q = '{8'hA5, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
      chk_bytes("s1", exp_q);
      chk("s1_seq", 32'(oSeq), 32'h1);
      chk("s1_reads", 32'(rd_cnt), 32'h1);

      // Round-robin over channels 1 and 3.
      do_reset();
      push(1, 32'hA1B2C3D4);
      push(3, 32'hDEADBEEF);
      iEnable = 1'b1;
      wait_done("s2", 400);
      exp_q = '{8'hA5, 8'h01, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h05,
                8'hA5, 8'h13, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h31};
      chk_bytes("s2", exp_q);
      chk("s2_reads", 32'(rd_cnt), 32'h2);
      chk("s2_onehot", 32'(onehot_err), 32'h0);

      // Back-pressure with ready pattern 1,0,0,1.
      do_reset();
      stall_mode = 1'b1;
      push(2, 32'h0102A0B0);
      stall_cycles = 0;
      iEnable = 1'b1;
      wait_done("s3", 400);
      exp_q = '{8'hA5, 8'h02, 8'hB0, 8'hA0, 8'h02, 8'h01, 8'h11};
      chk_bytes("s3", exp_q);
      chk("s3_hold", 32'(stall_viol), 32'h0);
      chk("s3_stalled", 32'(stall_cycles > 0), 32'h1);
      stall_mode = 1'b0;

      // 17 frames on channel 2: sequence wraps 15 -> 0.
      do_reset();
      for (int i = 0; i < 17; i++) push(2, 32'(i));
      iEnable = 1'b1;
      wait_done("s4", 2000);
      chk("s4_count", 32'(rx_q.size()), 32'd119);
      for (int i = 0; i < 17 && (7*i + 1) < rx_q.size(); i++) begin
         chk($sformatf("s4_hdr%0d", i), 32'(rx_q[7*i + 1]), 32'({i[3:0], 4'h2}));
      end
      chk("s4_seq", 32'(oSeq), 32'h1);

      // Enable drops during HDR: frame completes, nothing new starts.
      do_reset();
      push(0, 32'hCAFEF00D);
      push(0, 32'h12345678);
      iEnable = 1'b1;
      wait_bytes("s5_hdr", 2, 100);
      iEnable = 1'b0;
      wait_done("s5", 200);
      repeat (10) @(negedge iClk);
      chk("s5_count", 32'(rx_q.size()), 32'd7);
      if (rx_q.size() >= 3) begin
         chk("s5_hdrbyte", 32'(rx_q[1]), 32'h00);
         chk("s5_data0", 32'(rx_q[2]), 32'h0D);
      end
      chk("s5_reads", 32'(rd_cnt), 32'h1);
      chk("s5_busy", 32'(oBusy), 32'h0);
      chk("s5_left", 32'(iEmpty[0]), 32'h0);

      // Reset during DATA: outputs clear at once, next frame starts fresh.
      do_reset();
      iEnable = 1'b1;
      push(1, 32'h55667788);
      wait_bytes("s6_data", 3, 100);
      iRst = 1'b1;
      #1;
      chk_reset_outputs("s6_rst");
      @(negedge iClk);
      @(negedge iClk);
      iRst = 1'b0;
      flush();
      rx_q.delete();
      push(2, 32'h000000FF);
      wait_done("s6", 200);
      exp_q = '{8'hA5, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFD};
      chk_bytes("s6", exp_q);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
